// File: rtl/fme_pkg.sv
// Shared types and default sizing for the FME cost-select block.
package fme_pkg;
  localparam int N_CAND       = 9;
  localparam int BLK_PER_CAND = 16;
  localparam int SATD_W       = 16;
  localparam int MVC_W        = 12;
  localparam int ACC_W        = 21;

  typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_e;

  typedef logic [ACC_W-1:0] cost_t;
endpackage

// File: rtl/fme_cost_select_if.sv
// SATD stream from the processing unit: one 4x4 SATD per beat plus the candidate's MV rate.
interface fme_cost_select_if #(
  parameter int SATD_W = fme_pkg::SATD_W,
  parameter int MVC_W  = fme_pkg::MVC_W
) ();
  logic              satd_valid;
  logic              satd_ready;
  logic [SATD_W-1:0] satd_in;
  logic [MVC_W-1:0]  mv_cost;

  modport master (output satd_valid, satd_in, mv_cost, input satd_ready);
  modport slave  (input satd_valid, satd_in, mv_cost, output satd_ready);
endinterface

// File: rtl/fme_sat_acc.sv
// Saturating cost adder: load (satd + mv) on a candidate's first beat, else acc + satd.
module fme_sat_acc #(
  parameter int W      = fme_pkg::ACC_W,
  parameter int SATD_W = fme_pkg::SATD_W,
  parameter int MVC_W  = fme_pkg::MVC_W
) (
  input  logic              load_i,
  input  logic [W-1:0]      acc_i,
  input  logic [SATD_W-1:0] satd_i,
  input  logic [MVC_W-1:0]  mv_i,
  output logic [W-1:0]      sum_o
);
  logic [W:0] base;
  logic [W:0] sum;

  // One extra carry bit is enough: the addend is never wider than the accumulator.
  always_comb begin
    base  = load_i ? (W+1)'(mv_i) : {1'b0, acc_i};
    sum   = base + (W+1)'(satd_i);
    sum_o = sum[W] ? '1 : sum[W-1:0];
  end
endmodule

// File: rtl/fme_cost_select.sv
// Sums per-candidate SATD plus MV rate and reports the cheapest candidate of a search.
// Optional early termination of losing candidates: define FME_EARLY_TERM_EN.
module fme_cost_select #(
  parameter int N_CAND       = fme_pkg::N_CAND,
  parameter int BLK_PER_CAND = fme_pkg::BLK_PER_CAND,
  parameter int SATD_W       = fme_pkg::SATD_W,
  parameter int MVC_W        = fme_pkg::MVC_W,
  parameter int ACC_W        = fme_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  fme_cost_select_if.slave s,
  output logic             busy,
  output logic             done,
  output logic [3:0]       best_idx,
  output logic [ACC_W-1:0] best_cost
`ifdef FME_EARLY_TERM_EN
  ,
  output logic [3:0]       term_cnt
`endif
);
  import fme_pkg::*;

  localparam int BW = (BLK_PER_CAND > 1) ? $clog2(BLK_PER_CAND) : 1;

  state_e           state_q, state_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [3:0]       cand_q, cand_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] min_cost_q, min_cost_d;
  logic [3:0]       min_idx_q, min_idx_d;
  logic [3:0]       best_idx_q, best_idx_d;
  logic [ACC_W-1:0] best_cost_q, best_cost_d;
  logic [ACC_W-1:0] sum;
  logic             first;
  logic             upd;
`ifdef FME_EARLY_TERM_EN
  logic             skip_q, skip_d;
  logic [3:0]       term_q, term_d;
`endif

  assign first = (blk_q == '0);

  fme_sat_acc #(.W(ACC_W), .SATD_W(SATD_W), .MVC_W(MVC_W)) u_acc (
    .load_i (first),
    .acc_i  (acc_q),
    .satd_i (s.satd_in),
    .mv_i   (s.mv_cost),
    .sum_o  (sum)
  );

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    cand_d      = cand_q;
    acc_d       = acc_q;
    min_cost_d  = min_cost_q;
    min_idx_d   = min_idx_q;
    best_idx_d  = best_idx_q;
    best_cost_d = best_cost_q;
    upd         = 1'b0;
`ifdef FME_EARLY_TERM_EN
    skip_d      = skip_q;
    term_d      = term_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        blk_d      = '0;
        cand_d     = '0;
        min_cost_d = '1;
        min_idx_d  = '0;
`ifdef FME_EARLY_TERM_EN
        skip_d     = 1'b0;
        term_d     = '0;
`endif
        state_d    = ACCUM;
      end
      ACCUM: if (s.satd_valid) begin
        acc_d = sum;
`ifdef FME_EARLY_TERM_EN
        // Once a candidate can no longer win, its beats are drained but not added.
        if (first) skip_d = 1'b0;
        else if (skip_q) acc_d = acc_q;
        if (cand_q != '0 && acc_d >= min_cost_q) skip_d = 1'b1;
`endif
        blk_d = blk_q + 1'b1;
        if (blk_q == BW'(BLK_PER_CAND-1)) state_d = CMP;
      end
      CMP: begin
        upd = (acc_q < min_cost_q);
`ifdef FME_EARLY_TERM_EN
        if (skip_q) begin
          upd    = 1'b0;
          term_d = term_q + 1'b1;
        end
`endif
        if (upd) begin
          min_cost_d = acc_q;
          min_idx_d  = cand_q;
        end
        // Results are latched on entry to DONE so they are valid with the done pulse.
        if (cand_q == 4'(N_CAND-1)) begin
          best_idx_d  = min_idx_d;
          best_cost_d = min_cost_d;
          state_d     = DONE;
        end else begin
          cand_d  = cand_q + 1'b1;
          blk_d   = '0;
          state_d = ACCUM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      min_cost_q  <= '0;
      min_idx_q   <= '0;
      best_idx_q  <= '0;
      best_cost_q <= '0;
`ifdef FME_EARLY_TERM_EN
      skip_q      <= 1'b0;
      term_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      cand_q      <= cand_d;
      acc_q       <= acc_d;
      min_cost_q  <= min_cost_d;
      min_idx_q   <= min_idx_d;
      best_idx_q  <= best_idx_d;
      best_cost_q <= best_cost_d;
`ifdef FME_EARLY_TERM_EN
      skip_q      <= skip_d;
      term_q      <= term_d;
`endif
    end
  end

  assign s.satd_ready = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign best_idx     = best_idx_q;
  assign best_cost    = best_cost_q;
`ifdef FME_EARLY_TERM_EN
  assign term_cnt     = term_q;
`endif
endmodule
